// File: rtl/pca9685_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pca9685_pkg                                                      |
// | Register map, field positions and blob accessors for the PWM     |
// | output stage.                                                    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package pca9685_pkg;

   localparam int unsigned CNT_W     = 12;
   localparam int unsigned CH_STRIDE = 4;
   localparam int unsigned BLOB_W    = 2048;

   localparam logic [7:0] ADDR_MODE1     = 8'h00;
   localparam logic [7:0] ADDR_MODE2     = 8'h01;
   localparam logic [7:0] ADDR_LED0_ON_L = 8'h06;
   localparam logic [7:0] ADDR_PRE_SCALE = 8'hFE;

   localparam int unsigned BIT_SLEEP = 4;
   localparam int unsigned BIT_INVRT = 4;
   localparam int unsigned BIT_FULL  = 4;

   typedef struct packed {
      logic [CNT_W-1:0] on;
      logic [CNT_W-1:0] off;
      logic             full_on;
      logic             full_off;
   } chan_shadow_t;

   // Byte k occupies blob[k*8 : k*8+7] with bit k*8 as the byte MSB.
   function automatic logic [7:0] blob_byte(input logic [0:BLOB_W-1] blob,
                                            input logic [7:0]          addr);
      return blob[int'(addr)*8 +: 8];
   endfunction

   function automatic logic blob_bit(input logic [0:BLOB_W-1] blob,
                                     input logic [7:0]          addr,
                                     input int unsigned         pos);
      return blob[int'(addr)*8 + 7 - int'(pos)];
   endfunction

   function automatic logic [3:0] blob_nibble_lo(input logic [0:BLOB_W-1] blob,
                                                 input logic [7:0]          addr);
      return blob[int'(addr)*8 + 4 +: 4];
   endfunction

   function automatic chan_shadow_t decode_channel(input logic [0:BLOB_W-1] blob,
                                                   input int unsigned         ch);
      logic [7:0]   base;
      chan_shadow_t s;
      base       = ADDR_LED0_ON_L + 8'(CH_STRIDE * ch);
      s.on       = {blob_nibble_lo(blob, base + 8'd1), blob_byte(blob, base)};
      s.off      = {blob_nibble_lo(blob, base + 8'd3), blob_byte(blob, base + 8'd2)};
      s.full_on  = blob_bit(blob, base + 8'd1, BIT_FULL);
      s.full_off = blob_bit(blob, base + 8'd3, BIT_FULL);
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel_compare.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_channel_compare                                              |
// | Combinational raw level of one channel from the phase count.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pwm_channel_compare
   import pca9685_pkg::*;
(
   input  logic [CNT_W-1:0] count_i,
   input  logic [CNT_W-1:0] on_i,
   input  logic [CNT_W-1:0] off_i,
   input  logic             full_on_i,
   input  logic             full_off_i,
   output logic             raw_o
);

   always_comb begin
      raw_o = 1'b0;
      if (full_off_i) begin
         raw_o = 1'b0;
      end else if (full_on_i) begin
         raw_o = 1'b1;
      end else if (on_i < off_i) begin
         raw_o = (count_i >= on_i) && (count_i < off_i);
      end else if (on_i > off_i) begin
         raw_o = (count_i >= on_i) || (count_i < off_i);
      end
   end

endmodule
`default_nettype wire

// File: rtl/pwm_output_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pwm_output_stage                                                 |
// | Prescaler, shared phase counter, shadow bank and 16 PWM outputs. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pwm_output_stage
   import pca9685_pkg::*;
#(
   parameter int unsigned NUM_CHANNELS = 16,
   parameter int unsigned PRESCALE_MIN = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [0:BLOB_W-1]       register_blob_i,
   output logic [NUM_CHANNELS-1:0] pwm_o,
   output logic                    cycle_start_o,
   output logic [CNT_W-1:0]        counter_o
);

   function automatic logic [7:0] clamp_prescale(input logic [7:0] p);
      return (p < 8'(PRESCALE_MIN)) ? 8'(PRESCALE_MIN) : p;
   endfunction

   logic                    sleep;
   logic                    invrt;
   logic [7:0]              pre_scale_eff;
   logic [7:0]              prescale_use;
   logic                    tick;
   logic                    wrap;
   logic [7:0]              div_q, div_d;
   logic [7:0]              prescale_q, prescale_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    cycle_start_q, cycle_start_d;
   logic                    reload_pending_q, reload_pending_d;
   logic [NUM_CHANNELS-1:0] pwm_q, pwm_d;
   logic [NUM_CHANNELS-1:0] raw;
   chan_shadow_t            shadow_q [NUM_CHANNELS];
   chan_shadow_t            shadow_d [NUM_CHANNELS];
   chan_shadow_t            decoded  [NUM_CHANNELS];
   logic                    unused_blob;

   assign unused_blob   = ^register_blob_i;
   assign sleep         = blob_bit(register_blob_i, ADDR_MODE1, BIT_SLEEP);
   assign invrt         = blob_bit(register_blob_i, ADDR_MODE2, BIT_INVRT);
   assign pre_scale_eff = clamp_prescale(blob_byte(register_blob_i, ADDR_PRE_SCALE));
   // The stored prescale is zero straight out of reset, so clamp it again on use.
   assign prescale_use  = clamp_prescale(prescale_q);
   assign tick          = (div_q == prescale_use);
   assign wrap          = tick && (count_q == '1);

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      assign decoded[i] = decode_channel(register_blob_i, i);

      pwm_channel_compare u_cmp (
         .count_i    (count_q),
         .on_i       (shadow_q[i].on),
         .off_i      (shadow_q[i].off),
         .full_on_i  (shadow_q[i].full_on),
         .full_off_i (shadow_q[i].full_off),
         .raw_o      (raw[i])
      );
   end

   always_comb begin
      div_d            = div_q;
      count_d          = count_q;
      cycle_start_d    = 1'b0;
      reload_pending_d = reload_pending_q;
      prescale_d       = prescale_q;
      shadow_d         = shadow_q;
      pwm_d            = pwm_q;
      if (sleep) begin
         div_d            = '0;
         count_d          = '0;
         reload_pending_d = 1'b1;
         pwm_d            = '0;
      end else begin
         div_d            = tick ? 8'd0 : div_q + 8'd1;
         count_d          = tick ? count_q + 1'b1 : count_q;
         cycle_start_d    = wrap;
         reload_pending_d = 1'b0;
         pwm_d            = raw ^ {NUM_CHANNELS{invrt}};
         // Shadows only change at a period boundary or on wake, never mid-period.
         if (wrap || reload_pending_q) begin
            shadow_d   = decoded;
            prescale_d = pre_scale_eff;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q            <= '0;
         count_q          <= '0;
         cycle_start_q    <= 1'b0;
         reload_pending_q <= 1'b1;
         prescale_q       <= '0;
         pwm_q            <= '0;
         shadow_q         <= '{default: '0};
      end else begin
         div_q            <= div_d;
         count_q          <= count_d;
         cycle_start_q    <= cycle_start_d;
         reload_pending_q <= reload_pending_d;
         prescale_q       <= prescale_d;
         pwm_q            <= pwm_d;
         shadow_q         <= shadow_d;
      end
   end

   assign pwm_o         = pwm_q;
   assign cycle_start_o = cycle_start_q;
   assign counter_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pwm_output_stage                                              |
// | Self-checking bench: vector table feeding a scoreboard queue.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_pwm_output_stage;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [0:2047] blob  = '0;
   logic [15:0]   pwm_o;
   logic          cycle_start_o;
   logic [11:0]   counter_o;

   int total = 0;
   int bad   = 0;
   int edge_n = 0;
   int hi0 = 0;
   bit duty_en = 1'b0;

   typedef struct {
      int    probe;
      int    ofs;
      int    ch;
      bit    exp;
      bit    cs;
      string name;
   } vec_t;

   typedef struct {
      int    at_edge;
      int    ch;
      bit    exp_bit;
      int    exp_cnt;
      bit    exp_cs;
      string name;
   } sb_item_t;

   vec_t     tbl1[$];
   vec_t     tbl2[$];
   sb_item_t sb[$];

   pwm_output_stage #(.NUM_CHANNELS(16), .PRESCALE_MIN(3)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .register_blob_i (blob),
      .pwm_o           (pwm_o),
      .cycle_start_o   (cycle_start_o),
      .counter_o       (counter_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not end, got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
         edge_n++;
         if (duty_en && edge_n >= 2 && edge_n <= 16385) hi0 += int'(pwm_o[0]);
      end
   endtask

   task automatic set_byte(input int addr, input logic [7:0] val);
      blob[addr*8 +: 8] = val;
   endtask

   task automatic set_led(input int ch, input logic [11:0] on, input logic [11:0] off,
                          input bit fon, input bit foff);
      int b;
      b = 6 + 4 * ch;
      set_byte(b,     on[7:0]);
      set_byte(b + 1, {3'b000, fon, on[11:8]});
      set_byte(b + 2, off[7:0]);
      set_byte(b + 3, {3'b000, foff, off[11:8]});
   endtask

   // Reset pulse starting just after an edge; edge numbering restarts at release.
   task automatic pulse_reset();
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_i  = 1'b0;
      edge_n = 0;
   endtask

   task automatic push_vec(input vec_t v);
      sb.push_back('{4 * v.probe + v.ofs, v.ch, v.exp, v.probe % 4096, v.cs, v.name});
   endtask

   task automatic drain();
      sb_item_t it;
      while (sb.size() > 0) begin
         it = sb.pop_front();
         if (it.at_edge < edge_n) begin
            chk({it.name, " order"}, edge_n, it.at_edge);
         end else begin
            step(it.at_edge - edge_n);
            chk({it.name, " pwm"}, pwm_o[it.ch], it.exp_bit);
            chk({it.name, " cnt"}, counter_o, it.exp_cnt);
            chk({it.name, " cs"}, cycle_start_o, it.exp_cs);
         end
      end
   endtask

   initial begin
      // -------- reset state and default registers --------
      @(posedge clk_i); @(posedge clk_i);
      #1;
      chk("rst pwm", pwm_o, 16'h0000);
      chk("rst cnt", counter_o, 0);
      chk("rst cs", cycle_start_o, 0);
      rst_i  = 1'b0;
      edge_n = 0;
      step(2);  chk("dflt pwm e2", pwm_o, 16'h0000);
      step(1);  chk("dflt cnt e3", counter_o, 0);
      step(1);  chk("dflt cnt e4", counter_o, 1);
      step(4);  chk("dflt cnt e8", counter_o, 2);
      step(92); chk("dflt pwm e100", pwm_o, 16'h0000);
      chk("dflt cnt e100", counter_o, 25);

      // -------- configured full period, PRE_SCALE 0 clamps to 3 --------
      set_byte(8'hFE, 8'h00);
      set_led(0, 12'h000, 12'h800, 1'b0, 1'b0);
      set_led(1, 12'h005, 12'h005, 1'b1, 1'b0);
      set_led(2, 12'h123, 12'h123, 1'b0, 1'b0);
      set_led(3, 12'h000, 12'h000, 1'b1, 1'b1);
      set_led(5, 12'hF00, 12'h100, 1'b0, 1'b0);
      set_led(7, 12'h010, 12'h020, 1'b0, 1'b0);

      tbl1.push_back('{0,   2, 0, 1'b1, 1'b0, "c0@0"});
      tbl1.push_back('{0,   2, 1, 1'b1, 1'b0, "fullon@0"});
      tbl1.push_back('{0,   2, 2, 1'b0, 1'b0, "oneqoff@0"});
      tbl1.push_back('{0,   2, 3, 1'b0, 1'b0, "bothfull@0"});
      tbl1.push_back('{0,   2, 5, 1'b1, 1'b0, "c5@0"});
      tbl1.push_back('{15,  2, 7, 1'b0, 1'b0, "c7@15"});
      tbl1.push_back('{16,  2, 7, 1'b1, 1'b0, "c7@16"});
      tbl1.push_back('{31,  2, 7, 1'b1, 1'b0, "c7@31"});
      tbl1.push_back('{32,  2, 7, 1'b0, 1'b0, "c7@32"});
      tbl1.push_back('{255, 2, 5, 1'b1, 1'b0, "c5@255"});
      tbl1.push_back('{256, 2, 5, 1'b0, 1'b0, "c5@256"});

      tbl2.push_back('{1001, 2, 3, 1'b0, 1'b0, "c3 mid@1001"});
      tbl2.push_back('{2000, 2, 3, 1'b0, 1'b0, "c3 mid@2000"});
      tbl2.push_back('{2047, 2, 0, 1'b1, 1'b0, "c0@2047"});
      tbl2.push_back('{2048, 0, 0, 1'b1, 1'b0, "c0 lag@2048+0"});
      tbl2.push_back('{2048, 1, 0, 1'b0, 1'b0, "c0 lag@2048+1"});
      tbl2.push_back('{2048, 2, 0, 1'b0, 1'b0, "c0@2048"});
      tbl2.push_back('{3839, 2, 5, 1'b0, 1'b0, "c5@3839"});
      tbl2.push_back('{3840, 2, 5, 1'b1, 1'b0, "c5@3840"});
      tbl2.push_back('{4095, 2, 0, 1'b0, 1'b0, "c0@4095"});
      tbl2.push_back('{4095, 2, 5, 1'b1, 1'b0, "c5@4095"});
      tbl2.push_back('{4095, 3, 3, 1'b0, 1'b0, "prewrap"});
      tbl2.push_back('{4096, 0, 3, 1'b0, 1'b1, "wrap"});
      tbl2.push_back('{4096, 1, 3, 1'b1, 1'b0, "c3 newcycle"});
      tbl2.push_back('{4096, 1, 0, 1'b1, 1'b0, "c0 newcycle"});

      pulse_reset();
      duty_en = 1'b1;
      foreach (tbl1[i]) push_vec(tbl1[i]);
      drain();
      step(4000 - edge_n);
      set_led(3, 12'h000, 12'h000, 1'b1, 1'b0);
      foreach (tbl2[i]) push_vec(tbl2[i]);
      drain();
      duty_en = 1'b0;
      chk("c0 duty high clocks", hi0, 8192);

      // -------- INVRT and SLEEP --------
      set_byte(8'h01, 8'h10);
      pulse_reset();
      step(2);
      chk("inv c0@0", pwm_o[0], 1'b0);
      chk("inv c2@0", pwm_o[2], 1'b1);
      step(8194 - edge_n);
      chk("inv c0@2048", pwm_o[0], 1'b1);
      set_byte(8'h00, 8'h10);
      step(1);
      chk("sleep pwm", pwm_o, 16'h0000);
      chk("sleep cnt", counter_o, 0);
      chk("sleep cs", cycle_start_o, 0);
      step(10);
      chk("sleep hold cnt", counter_o, 0);
      chk("sleep hold pwm", pwm_o, 16'h0000);
      set_byte(8'h00, 8'h00);
      step(2);
      chk("wake c0", pwm_o[0], 1'b0);
      chk("wake c2", pwm_o[2], 1'b1);
      step(1);
      chk("wake cnt e3", counter_o, 0);
      step(1);
      chk("wake cnt e4", counter_o, 1);
      chk("wake cs", cycle_start_o, 0);

      // -------- async reset at count 1000 --------
      set_byte(8'h01, 8'h00);
      pulse_reset();
      step(4002);
      chk("pre-rst cnt", counter_o, 1000);
      chk("pre-rst c0", pwm_o[0], 1'b1);
      set_led(4, 12'h000, 12'h001, 1'b0, 1'b0);
      rst_i = 1'b1;
      #1;
      chk("async rst pwm", pwm_o, 16'h0000);
      chk("async rst cnt", counter_o, 0);
      chk("async rst cs", cycle_start_o, 0);
      #2;
      rst_i  = 1'b0;
      edge_n = 0;
      step(2);
      chk("reload c4@0", pwm_o[4], 1'b1);
      chk("reload c0@0", pwm_o[0], 1'b1);
      step(4);
      chk("reload c4@1", pwm_o[4], 1'b0);
      chk("reload cnt", counter_o, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pwm_output_stage.md
# pwm_output_stage

Consumes the flattened register file image produced by the register store and drives the 16 PWM output pins with PCA9685 semantics. It contains the prescaler, the shared 12-bit phase counter, a shadow copy of the per-channel ON/OFF values, and one compare unit per channel. It sits directly downstream of the register store and directly upstream of the output pads.

## Interface
- NUM_CHANNELS, 16, number of PWM outputs; LED n registers start at byte 0x06 + 4n.
- PRESCALE_MIN, 3, lower clamp applied to PRE_SCALE.
- clk_i  input  1  system clock.
- rst_i  input  1  reset: one clock; asynchronous, active-high.
- register_blob_i  input  [0:2047]  register image; byte k = bits [k*8 : k*8+7], bit k*8 is the byte MSB.
- pwm_o  output  [NUM_CHANNELS-1:0]  channel outputs, registered.
- cycle_start_o  output  1  one-clock pulse when the counter wraps 4095->0.
- counter_o  output  12  current phase count (debug/verification).

## Operation
- Register fields used:
  - MODE1 (0x00) bit4 = SLEEP.
  - MODE2 (0x01) bit4 = INVRT.
  - PRE_SCALE (0xFE).
  - Per channel: ON_L, ON_H, OFF_L, OFF_H.
  - ON/OFF = {H[3:0], L}. ON_H bit4 = FULL_ON; OFF_H bit4 = FULL_OFF.
- Prescaler:
  - Effective prescale P = max(PRE_SCALE, PRESCALE_MIN).
  - An 8-bit divider counts 0..P; a tick is emitted when it equals P, and the divider then returns to 0.
  - One counter step occurs every P+1 clocks.
- Phase counter: 12 bits, increments on each tick, wraps 4095->0.
- Shadow registers:
  - Hold ON, OFF, FULL_ON, FULL_OFF for every channel, plus P.
  - Reloaded from register_blob_i on the clock where the counter wraps, and on the first clock after SLEEP clears.
  - Writes to the register store never change the running cycle mid-period (no glitches).
- Per-channel raw level, evaluated on the shadow values in this priority order:
  1. FULL_OFF -> 0.
  2. FULL_ON -> 1.
  3. ON < OFF -> 1 when ON <= count < OFF.
  4. ON > OFF -> 1 when count >= ON or count < OFF.
  5. ON == OFF -> 0.
- Output: pwm_o = raw XOR INVRT, where INVRT is read live from MODE2.
- Sleep:
  - While SLEEP = 1, the divider, counter and cycle_start_o are held at 0.
  - pwm_o is forced to 0 regardless of INVRT.
  - On SLEEP 1->0, the shadow registers reload and counting resumes from 0.
  - No cycle_start_o pulse is generated for the resume.

## Timing
- Reset values:
  - pwm_o = 0, cycle_start_o = 0, counter_o = 0, divider = 0.
  - All shadow fields = 0, which gives ON == OFF, so outputs stay low.
- After rst_i deasserts, the first counter step occurs P+1 clocks later.
- The shadow registers load on the first clock after reset, so they do not wait for a wrap.
- pwm_o latency: one clock after counter_o takes a value, pwm_o reflects the comparison for that value.
- cycle_start_o is asserted in the same clock that counter_o becomes 0 after 4095.
- Reset asserted mid-cycle: all state clears immediately (asynchronously); no partial pulses are held.
- Simultaneous wrap and register change: the shadow captures the blob value sampled on the wrap clock.
- PRE_SCALE change: takes effect at the next wrap; the divider is not reset mid-period.
- Full period = 4096 × (P+1) clocks.

## Structure
- Shared package `pca9685_pkg`:
  - Register address constants: MODE1, MODE2, LED0_ON_L, PRE_SCALE.
  - Bit positions: SLEEP, INVRT, FULL bit.
  - Counter width (12) and channel stride (4).
  - Function `blob_byte(blob, addr)`.
- Sub-module `pwm_channel_compare`:
  - Inputs: count, shadow ON/OFF, FULL_ON, FULL_OFF.
  - Output: combinational raw level.
  - Instantiated NUM_CHANNELS times via generate.
- Top level holds the prescaler, counter, shadow bank, sleep logic and output register.

## Test plan
- Reset then default registers (all 0, PRE_SCALE 0 -> clamped to 3):
  - pwm_o stays 0.
  - counter_o steps every 4 clocks.
  - cycle_start_o first pulses 16384 clocks after reset release.
- LED0 ON = 0x000, OFF = 0x800, PRE_SCALE = 3:
  - pwm_o[0] high for counts 0..2047 and low for 2048..4095.
  - Duty cycle 50%; edges lag counter_o by 1 clock.
- LED5 ON = 0xF00, OFF = 0x100 (wrap case):
  - pwm_o[5] high for counts ≥ 3840 and < 256; low otherwise.
- LED3 with both FULL_ON and FULL_OFF set:
  - pwm_o[3] = 0.
  - Clearing FULL_OFF mid-cycle gives pwm_o[3] = 1 only after the next cycle_start_o.
- INVRT = 1 with LED0 at 50%: pwm_o[0] is the inverse of the previous case; setting SLEEP forces all pwm_o = 0 and counter_o = 0.
- rst_i pulse asserted at count 1000:
  - All outputs are 0 and the counter is 0 within the same clock.
  - Shadows reload from the blob afterwards.
